// File: rtl/blink_rate_ctrl.sv
// Button-driven blink control: synchronize, debounce, classify short/long presses,
// step the blink rate or pause/resume, and emit a one-cycle tick at the selected rate.
module blink_rate_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned LONG_CYCLES     = 50000000,
  parameter int unsigned BASE_PERIOD     = 50000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn,
  output logic       tick,
  output logic [1:0] rate,
  output logic       running,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PRESS = 2'd1,
    S_LONG  = 2'd2
  } state_e;

  localparam logic [31:0] DEB_LAST  = 32'(DEBOUNCE_CYCLES - 1);
  localparam logic [31:0] LONG_LAST = 32'(LONG_CYCLES - 1);
  localparam logic [31:0] BASE_W    = 32'(BASE_PERIOD);

  logic        sync1_q, sync2_q;
  logic        deb_q, deb_d, deb_prev_q;
  logic [31:0] deb_cnt_q, deb_cnt_d;
  state_e      state_q, state_d;
  logic [31:0] hold_q, hold_d;
  logic [1:0]  rate_q, rate_d;
  logic        running_q, running_d;
  logic [31:0] pcnt_q, pcnt_d;
  logic        tick_q, tick_d;
  logic [31:0] period_last;
  logic        deb_rise, deb_fall;

  always_comb begin
    deb_d     = deb_q;
    deb_cnt_d = '0;
    if (sync2_q != deb_q) begin
      if (deb_cnt_q == DEB_LAST) begin
        deb_d = sync2_q;
      end else begin
        deb_cnt_d = deb_cnt_q + 32'd1;
      end
    end
  end

  assign deb_rise = deb_q & ~deb_prev_q;
  assign deb_fall = ~deb_q & deb_prev_q;

  // The long-press threshold is checked before the release so a release landing on
  // the threshold cycle still counts as a long press; LONG then exits on the level.
  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    rate_d    = rate_q;
    running_d = running_q;
    case (state_q)
      S_IDLE: begin
        if (deb_rise) begin
          state_d = S_PRESS;
          hold_d  = '0;
        end
      end
      S_PRESS: begin
        if (hold_q == LONG_LAST) begin
          running_d = ~running_q;
          state_d   = S_LONG;
        end else if (deb_fall) begin
          rate_d  = rate_q + 2'd1;
          state_d = S_IDLE;
        end else begin
          hold_d = hold_q + 32'd1;
        end
      end
      S_LONG: begin
        if (!deb_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign period_last = (BASE_W >> rate_q) - 32'd1;

  // Any rate/run change restarts the period so the first new tick is a full P away.
  always_comb begin
    pcnt_d = '0;
    tick_d = 1'b0;
    if ((rate_d == rate_q) && (running_d == running_q) && running_q) begin
      if (pcnt_q == period_last) begin
        tick_d = 1'b1;
      end else begin
        pcnt_d = pcnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      deb_q      <= 1'b0;
      deb_prev_q <= 1'b0;
      deb_cnt_q  <= '0;
      state_q    <= S_IDLE;
      hold_q     <= '0;
      rate_q     <= 2'd0;
      running_q  <= 1'b1;
      pcnt_q     <= '0;
      tick_q     <= 1'b0;
    end else begin
      sync1_q    <= btn;
      sync2_q    <= sync1_q;
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      deb_cnt_q  <= deb_cnt_d;
      state_q    <= state_d;
      hold_q     <= hold_d;
      rate_q     <= rate_d;
      running_q  <= running_d;
      pcnt_q     <= pcnt_d;
      tick_q     <= tick_d;
    end
  end

  assign tick      = tick_q;
  assign rate      = rate_q;
  assign running   = running_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_blink_rate_ctrl.sv
// Bench for blink_rate_ctrl with small parameters: table of button presses with
// expected rate/run/tick period, plus directed glitch, threshold and reset sequences.
module tb_blink_rate_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn = 1'b0;
  logic       tick;
  logic [1:0] rate;
  logic       running;
  logic [1:0] state_dbg;

  always #5 clk = ~clk;

  blink_rate_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .LONG_CYCLES(20),
    .BASE_PERIOD(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .btn(btn),
    .tick(tick),
    .rate(rate),
    .running(running),
    .state_dbg(state_dbg)
  );

  typedef struct {
    int hold;
    int exp_rate;
    int exp_run;
    int exp_per;
  } vec_t;

  vec_t vecs[8];
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;

  int         chg_cyc = 0;
  int         first_after = -1;
  int         ticks_since_chg = 0;
  int         tick_total = 0;
  int         last_tick = 0;
  int         last_gap = 0;
  int         width_err = 0;
  logic [1:0] prev_rate = 2'd0;
  logic       prev_run = 1'b1;
  logic       prev_tick = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_rate = rate;
      prev_run  = running;
      prev_tick = 1'b0;
    end else begin
      if (rate !== prev_rate || running !== prev_run) begin
        chg_cyc         = cyc;
        first_after     = -1;
        ticks_since_chg = 0;
      end
      if (tick) begin
        tick_total++;
        ticks_since_chg++;
        if (first_after < 0) first_after = cyc;
        last_gap  = cyc - last_tick;
        last_tick = cyc;
        if (prev_tick) width_err++;
      end
      prev_rate = rate;
      prev_run  = running;
      prev_tick = tick;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic press(input int h);
    @(negedge clk);
    btn = 1'b1;
    repeat (h) @(negedge clk);
    btn = 1'b0;
  endtask

  initial begin
    #1000000;
    n_fail++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    int start_ticks;
    int found;
    int spent;
    int saw_press;

    vecs[0] = '{hold: 8,  exp_rate: 1, exp_run: 1, exp_per: 8};
    vecs[1] = '{hold: 8,  exp_rate: 2, exp_run: 1, exp_per: 4};
    vecs[2] = '{hold: 8,  exp_rate: 3, exp_run: 1, exp_per: 2};
    vecs[3] = '{hold: 8,  exp_rate: 0, exp_run: 1, exp_per: 16};
    vecs[4] = '{hold: 40, exp_rate: 0, exp_run: 0, exp_per: 0};
    vecs[5] = '{hold: 8,  exp_rate: 1, exp_run: 0, exp_per: 0};
    vecs[6] = '{hold: 40, exp_rate: 1, exp_run: 1, exp_per: 8};
    vecs[7] = '{hold: 8,  exp_rate: 2, exp_run: 1, exp_per: 4};

    // Reset values and free-running ticks at rate 0
    idle(3);
    chk("reset_tick", int'(tick), 0);
    chk("reset_rate", int'(rate), 0);
    chk("reset_running", int'(running), 1);
    chk("reset_state", int'(state_dbg), 0);
    start_ticks = tick_total;
    rst_n = 1'b1;
    idle(100);
    chk("idle_tick_count", tick_total - start_ticks, 6);
    chk("idle_tick_gap", last_gap, 16);
    chk("idle_rate", int'(rate), 0);
    chk("idle_running", int'(running), 1);

    // Reset while tick is high must clear it immediately
    found = 0;
    for (int i = 0; i < 40 && found == 0; i++) begin
      @(negedge clk);
      if (tick) found = 1;
    end
    chk("tick_seen_before_reset", found, 1);
    rst_n = 1'b0;
    #1;
    chk("async_reset_tick", int'(tick), 0);
    idle(2);
    rst_n = 1'b1;
    idle(5);

    for (int i = 0; i < 8; i++) begin
      press(vecs[i].hold);
      idle(60);
      chk($sformatf("vec%0d_rate", i), int'(rate), vecs[i].exp_rate);
      chk($sformatf("vec%0d_running", i), int'(running), vecs[i].exp_run);
      if (vecs[i].exp_run != 0) begin
        chk($sformatf("vec%0d_first_tick", i), first_after - chg_cyc, vecs[i].exp_per);
        chk($sformatf("vec%0d_tick_gap", i), last_gap, vecs[i].exp_per);
      end else begin
        chk($sformatf("vec%0d_paused_ticks", i), ticks_since_chg, 0);
      end
    end

    // Bouncy button: no pulse long enough to pass the debouncer
    spent = 0;
    saw_press = 0;
    while (spent < 30) begin
      int hi;
      int lo;
      hi = $urandom_range(1, 3);
      lo = $urandom_range(1, 3);
      btn = 1'b1;
      repeat (hi) begin
        @(negedge clk);
        if (state_dbg != 2'd0) saw_press = 1;
      end
      btn = 1'b0;
      repeat (lo) begin
        @(negedge clk);
        if (state_dbg != 2'd0) saw_press = 1;
      end
      spent += hi + lo;
    end
    idle(20);
    chk("bounce_no_press", saw_press, 0);
    chk("bounce_rate", int'(rate), 2);
    chk("bounce_running", int'(running), 1);

    // Debounce boundary: 3 stable cycles rejected, 4 accepted as a short press
    press(3);
    idle(30);
    chk("glitch3_rate", int'(rate), 2);
    press(4);
    idle(30);
    chk("pulse4_rate", int'(rate), 3);

    // Long-press threshold: 19-cycle hold is short, 20 releases on the threshold cycle
    press(19);
    idle(40);
    chk("hold19_rate", int'(rate), 0);
    chk("hold19_running", int'(running), 1);
    press(20);
    idle(40);
    chk("hold20_rate", int'(rate), 0);
    chk("hold20_running", int'(running), 0);
    chk("hold20_state_idle", int'(state_dbg), 0);
    press(40);
    idle(40);
    chk("resume_running", int'(running), 1);
    chk("resume_rate", int'(rate), 0);
    chk("resume_first_tick", first_after - chg_cyc, 16);
    press(8);
    idle(40);
    chk("after_resume_rate", int'(rate), 1);

    // Reset mid-press with the button held through release
    @(negedge clk);
    btn = 1'b1;
    idle(10);
    chk("mid_press_state", int'(state_dbg), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_press_reset_rate", int'(rate), 0);
    chk("mid_press_reset_running", int'(running), 1);
    chk("mid_press_reset_state", int'(state_dbg), 0);
    chk("mid_press_reset_tick", int'(tick), 0);
    idle(3);
    rst_n = 1'b1;
    idle(8);
    btn = 1'b0;
    idle(30);
    chk("repress_rate", int'(rate), 1);
    chk("repress_running", int'(running), 1);

    chk("tick_width", width_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
